sobel_stream_master: RTL
========================

# sobel_stream_master

Memory-to-stream driver and stream-to-memory collector for the Sobel filter datapath. It reads `IMG_W*IMG_H` 32-bit pixel words from a source SRAM port in raster order and presents them on the filter's rgb input channel. It accepts the filter's result words on the avg channel and writes them sequentially to a destination SRAM port. It sits on the opposite end of both filter channels: it is the producer of rgb and the consumer of avg.

## Interface
- `IMG_W`, 256: pixels per row.
- `IMG_H`, 256: rows per frame.
- `AW`, 16: SRAM address width; must satisfy `2^AW >= IMG_W*IMG_H`.

- `i_clk`, in, 1: clock; all logic is on the rising edge.
- `i_rst`, in, 1: reset, synchronous and active-high.
- `i_start`, in, 1: one-cycle start pulse; sampled only in IDLE.
- `o_busy`, out, 1: high in RUN and DRAIN.
- `o_done`, out, 1: one-cycle pulse in DONE.
- `o_cycles`, out, 32: cycles from start to done; holds its value until the next start.
- `o_src_en`, out, 1: source read enable.
- `o_src_addr`, out, AW: source read address.
- `i_src_data`, in, 32: source read data, valid exactly 1 cycle after `o_src_en`.
- `o_rgb_vld`, out, 1: rgb word valid.
- `o_rgb_data`, out, 32: rgb word.
- `i_rgb_busy`, in, 1: filter cannot accept an rgb word.
- `i_avg_vld`, in, 1: result word valid.
- `i_avg_data`, in, 32: result word.
- `o_avg_busy`, out, 1: this block cannot accept a result word.
- `o_dst_we`, out, 1: destination write enable.
- `o_dst_addr`, out, AW: destination write address.
- `o_dst_data`, out, 32: destination write data.

## Operation
- **Transfer rule, both channels:** a word moves on a rising edge where `vld=1` and `busy=0`.
  - A producer holding `vld=1` with `busy=1` keeps `vld` and `data` stable until the transfer happens.
  - `vld` never drops without a transfer.
- **Constants:** `N = IMG_W*IMG_H`. The counters are `rd_cnt` (reads issued), `tx_cnt` (rgb transfers) and `rx_cnt` (avg transfers), each AW+1 bits wide.
- **States:**
  - IDLE: on `i_start`, clear all counters and `o_cycles`, then go to RUN.
  - RUN: issue reads and send rgb words. Go to DRAIN on the edge where `tx_cnt` reaches N.
  - DRAIN: go to DONE on the edge where `rx_cnt` reaches N. Results are also collected during RUN, so DRAIN may last 0 extra cycles' worth of transfers.
  - DONE: lasts 1 cycle, then go to IDLE.
- **Prefetch:** a 2-entry FIFO sits between the source read data and the rgb channel.
  - Issue a read when state is RUN, `rd_cnt < N`, and (FIFO occupancy + reads in flight) < 2.
  - `o_src_addr = rd_cnt[AW-1:0]`.
  - Read data is pushed into the FIFO the cycle after the read.
  - `o_rgb_vld` = FIFO not empty; `o_rgb_data` = FIFO head.
  - This sustains 1 word/cycle while `i_rgb_busy=0`.
- **Result path:**
  - `o_avg_busy = !(state==RUN || state==DRAIN)`.
  - Each avg transfer produces, in the same cycle combinationally, `o_dst_we=1`, `o_dst_addr=rx_cnt[AW-1:0]`, `o_dst_data=i_avg_data`, and increments `rx_cnt`.
  - Results beyond N cannot be accepted, because `o_avg_busy` returns to 1 after DONE.
- **Cycle counter:** `o_cycles` increments every cycle in RUN or DRAIN. It saturates at `32'hFFFF_FFFF`.
- **Simultaneous events:**
  - An rgb transfer, an avg transfer and a FIFO push may all happen in one cycle. Occupancy is updated as +push −pop.
  - `i_start` in any state other than IDLE is ignored.
- **Reset mid-frame:** on the next edge, state goes to IDLE, the FIFO and counters are cleared, and in-flight read data is discarded. No partial write follows reset.

## Timing
- **Reset values:**
  - `o_busy`, `o_done`, `o_src_en`, `o_rgb_vld` and `o_dst_we` are 0.
  - `o_avg_busy` is 1.
  - `o_src_addr`, `o_rgb_data`, `o_dst_addr`, `o_dst_data` and `o_cycles` are 0.
- **Start sequence:** with `i_start` high at edge 0, `o_busy=1` and `o_src_en=1` with addr 0 in cycle 1. `o_rgb_vld=1` with word 0 appears in cycle 2.
- **Best-case frame:** with `i_rgb_busy` always 0 and results returned 1 cycle after each rgb transfer, `o_done` pulses in cycle N+3 and `o_cycles = N+2`.
- **Combinational paths:** `o_avg_busy` has no combinational path from `i_avg_vld`. `o_rgb_vld` has no combinational path from `i_rgb_busy`.

## Test plan
- **Basic frame:** IMG_W=4, IMG_H=2, source word k = 0x00A0_0000+k, a stub filter echoes each rgb word +1 after 1 cycle, busy=0. Required: destination k = 0x00A0_0001+k for k=0..7, one `o_done` pulse, `o_cycles=10`.
- **Backpressure:** hold `i_rgb_busy=1` for cycles 3–7 and on alternate cycles afterwards. Required: no word is lost or duplicated, `o_rgb_data` is stable while stalled, and reads never exceed 2 outstanding.
- **Delayed results:** the stub returns all 8 results in a burst 20 cycles after the last rgb transfer. Required: the block stays in DRAIN with `o_busy=1`, writes addresses 0..7 in order, and `o_cycles` reflects the delay.
- **Start while busy:** pulse `i_start` during RUN and again during DRAIN. Required: counters are not reset, and exactly one `o_done` pulse occurs.
- **Reset mid-frame:** assert `i_rst` after 3 rgb transfers, then start again. Required: all outputs return to their reset values the next cycle, and the second frame completes correctly from address 0.

Source files
------------

// File: rtl/sobel_stream_master_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : sobel_stream_master_if                                           |
// | Purpose  : Source SRAM, rgb/avg stream and destination SRAM signal bundle.  |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
interface sobel_stream_master_if #(
  parameter int AW = 16
);
  logic          o_src_en;
  logic [AW-1:0] o_src_addr;
  logic [31:0]   i_src_data;
  logic          o_rgb_vld;
  logic [31:0]   o_rgb_data;
  logic          i_rgb_busy;
  logic          i_avg_vld;
  logic [31:0]   i_avg_data;
  logic          o_avg_busy;
  logic          o_dst_we;
  logic [AW-1:0] o_dst_addr;
  logic [31:0]   o_dst_data;

  modport master (
    output o_src_en, o_src_addr,
    input  i_src_data,
    output o_rgb_vld, o_rgb_data,
    input  i_rgb_busy,
    input  i_avg_vld, i_avg_data,
    output o_avg_busy,
    output o_dst_we, o_dst_addr, o_dst_data
  );

  modport slave (
    input  o_src_en, o_src_addr,
    output i_src_data,
    input  o_rgb_vld, o_rgb_data,
    output i_rgb_busy,
    output i_avg_vld, i_avg_data,
    input  o_avg_busy,
    input  o_dst_we, o_dst_addr, o_dst_data
  );
endinterface
`default_nettype wire

// File: rtl/sobel_stream_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : sobel_stream_master                                              |
// | Purpose  : Streams a frame from source SRAM to the filter rgb channel and   |
// |            writes filter avg results sequentially to destination SRAM.      |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module sobel_stream_master #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int AW    = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_cycles,
  sobel_stream_master_if.master bus
);

  localparam logic [AW:0] c_N = (AW+1)'(IMG_W * IMG_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [AW:0] r_rd_cnt;
  logic [AW:0] r_tx_cnt;
  logic [AW:0] r_rx_cnt;
  logic [31:0] r_cycles;

  logic [31:0] r_fifo [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_occ;
  logic        r_inflight;

  logic        w_run;
  logic        w_active;
  logic [2:0]  w_pending;
  logic        w_src_en;
  logic        w_rgb_vld;
  logic        w_rgb_fire;
  logic        w_bypass;
  logic [31:0] w_rgb_data;
  logic        w_push;
  logic        w_pop;
  logic        w_avg_fire;
  logic [AW:0] w_tx_nxt;
  logic [AW:0] w_rx_nxt;
  logic        w_start_ok;

  // Datapath: prefetch control, FIFO head selection and handshake events.
  always_comb begin
    w_run      = (r_state == S_RUN);
    w_active   = w_run || (r_state == S_DRAIN);
    w_start_ok = (r_state == S_IDLE) && i_start;
    w_pending  = {1'b0, r_occ} + {2'b00, r_inflight};
    w_src_en   = w_run && (r_rd_cnt < c_N) && (w_pending < 3'd2);
    // Word returning from SRAM this cycle is visible at once when the FIFO is empty.
    w_rgb_vld  = w_run && ((r_occ != 2'd0) || r_inflight);
    w_bypass   = (r_occ == 2'd0);
    w_rgb_fire = w_rgb_vld && !bus.i_rgb_busy;
    w_rgb_data = '0;
    if (w_rgb_vld) begin
      w_rgb_data = w_bypass ? bus.i_src_data : r_fifo[r_rd_ptr];
    end
    w_pop      = w_rgb_fire && !w_bypass;
    w_push     = r_inflight && !(w_bypass && w_rgb_fire);
    w_avg_fire = bus.i_avg_vld && w_active;
    w_tx_nxt   = r_tx_cnt + {{AW{1'b0}}, w_rgb_fire};
    w_rx_nxt   = r_rx_cnt + {{AW{1'b0}}, w_avg_fire};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_busy         = w_active;
    o_done         = (r_state == S_DONE);
    o_cycles       = r_cycles;
    bus.o_src_en   = w_src_en;
    bus.o_src_addr = r_rd_cnt[AW-1:0];
    bus.o_rgb_vld  = w_rgb_vld;
    bus.o_rgb_data = w_rgb_data;
    bus.o_avg_busy = !w_active;
    bus.o_dst_we   = w_avg_fire;
    bus.o_dst_addr = '0;
    bus.o_dst_data = '0;
    if (w_avg_fire) begin
      bus.o_dst_addr = r_rx_cnt[AW-1:0];
      bus.o_dst_data = bus.i_avg_data;
    end
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_tx_nxt == c_N) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_rx_nxt == c_N) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_cycles   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_src_en;
      if (w_start_ok) begin
        r_rd_cnt <= '0;
        r_tx_cnt <= '0;
        r_rx_cnt <= '0;
        r_cycles <= '0;
      end else begin
        if (w_src_en) begin
          r_rd_cnt <= r_rd_cnt + {{AW{1'b0}}, 1'b1};
        end
        r_tx_cnt <= w_tx_nxt;
        r_rx_cnt <= w_rx_nxt;
        if (w_active && (r_cycles != 32'hFFFF_FFFF)) begin
          r_cycles <= r_cycles + 32'd1;
        end
      end
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // FIFO storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.i_src_data;
    end
  end

endmodule
`default_nettype wire
